// File: rtl/cwc_pkg.sv
// Shared types and default sizing for the ChipWatcher capture path.
package cwc_pkg;

  localparam int CWC_ADDR_WIDTH = 16;
  localparam int CWC_DEPTH      = 2730;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } cwc_cap_state_t;

  function automatic logic cwc_is_capturing(input cwc_cap_state_t s);
    return (s == PRE) || (s == WAIT) || (s == POST);
  endfunction

endpackage

// File: rtl/cwc_capture_ctrl_if.sv
// Control, trace-RAM write port and status bundle of the capture sequencer.
interface cwc_capture_ctrl_if
  import cwc_pkg::*;
#(
  parameter int ADDR_WIDTH = CWC_ADDR_WIDTH
);
  logic                  arm;
  logic                  abort;
  logic                  sample_en;
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] pre_len;
  logic                  wt_ce;
  logic                  wt_en;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic                  busy;
  logic                  triggered;
  logic                  done;
  logic                  wrapped;
  logic [ADDR_WIDTH-1:0] trig_addr;

  modport master (
    output arm, abort, sample_en, trigger, pre_len,
    input  wt_ce, wt_en, wt_addr, busy, triggered, done, wrapped, trig_addr
  );

  modport slave (
    input  arm, abort, sample_en, trigger, pre_len,
    output wt_ce, wt_en, wt_addr, busy, triggered, done, wrapped, trig_addr
  );
endinterface

// File: rtl/cwc_wrap_ptr.sv
// Modulo-DEPTH pointer with clear/increment; wrap pulses when DEPTH-1 rolls to 0.
module cwc_wrap_ptr #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 2730
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  wrap
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Next pointer: explicit compare against the last entry, not binary overflow.
  always_comb begin
    ptr_d = ptr_q;
    wrap  = 1'b0;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
        wrap  = 1'b1;
      end else begin
        ptr_d = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/cwc_capture_ctrl.sv
// Trace-capture sequencer: pre/post-trigger window over a circular trace RAM.
module cwc_capture_ctrl
  import cwc_pkg::*;
#(
  parameter int ADDR_WIDTH = CWC_ADDR_WIDTH,
  parameter int DEPTH      = CWC_DEPTH
) (
  input  logic               trig_clk,
  input  logic               trig_rst,
  cwc_capture_ctrl_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  cwc_cap_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] pre_eff_q, pre_eff_d;
  logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_WIDTH-1:0] post_rem_q, post_rem_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] wt_addr_q, wt_addr_d;
  logic                  triggered_q, triggered_d;
  logic                  wrapped_q, wrapped_d;
  logic                  wt_en_q, wt_en_d;
  logic                  wt_ce_q, wt_ce_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  arm_acc_s;
  logic                  qual_s;
  logic [ADDR_WIDTH-1:0] pre_clamp_s;
  logic [ADDR_WIDTH-1:0] ptr_s;
  logic                  ptr_wrap_s;
  logic                  ptr_clr_s;
  logic                  ptr_inc_s;

  assign arm_acc_s   = bus.arm && !bus.abort && ((state_q == IDLE) || (state_q == DONE));
  assign qual_s      = bus.sample_en && !bus.abort && cwc_is_capturing(state_q);
  assign pre_clamp_s = (bus.pre_len > LAST) ? LAST : bus.pre_len;
  assign ptr_clr_s   = bus.abort || arm_acc_s;
  assign ptr_inc_s   = qual_s;

  cwc_wrap_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_wr_ptr (
    .clk  (trig_clk),
    .rst  (trig_rst),
    .clr  (ptr_clr_s),
    .inc  (ptr_inc_s),
    .ptr  (ptr_s),
    .wrap (ptr_wrap_s)
  );

  // Sequencer next-state and window counters.
  always_comb begin
    state_d     = state_q;
    pre_eff_d   = pre_eff_q;
    pre_cnt_d   = pre_cnt_q;
    post_rem_d  = post_rem_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    wt_addr_d   = wt_addr_q;
    wt_en_d     = 1'b0;
    if (bus.abort) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
    end else if (arm_acc_s) begin
      pre_eff_d   = pre_clamp_s;
      pre_cnt_d   = pre_clamp_s;
      post_rem_d  = '0;
      trig_addr_d = '0;
      triggered_d = 1'b0;
      state_d     = (pre_clamp_s != '0) ? PRE : WAIT;
    end else if (qual_s) begin
      wt_en_d   = 1'b1;
      wt_addr_d = ptr_s;
      case (state_q)
        PRE: begin
          pre_cnt_d = pre_cnt_q - ONE;
          state_d   = (pre_cnt_q == ONE) ? WAIT : PRE;
        end
        WAIT: begin
          if (bus.trigger) begin
            triggered_d = 1'b1;
            trig_addr_d = ptr_s;
            post_rem_d  = LAST - pre_eff_q;
            state_d     = (LAST == pre_eff_q) ? DONE : POST;
          end else begin
            state_d = WAIT;
          end
        end
        POST: begin
          post_rem_d = post_rem_q - ONE;
          state_d    = (post_rem_q == ONE) ? DONE : POST;
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Wrap flag kept apart from the sequencer so the pointer's wrap pulse feeds forward only.
  always_comb begin
    wrapped_d = wrapped_q;
    if (bus.abort || arm_acc_s) begin
      wrapped_d = 1'b0;
    end else begin
      wrapped_d = wrapped_q || ptr_wrap_s;
    end
  end

  // Status and strobe values as they will appear after the next edge.
  always_comb begin
    busy_d  = cwc_is_capturing(state_d);
    done_d  = (state_d == DONE);
    wt_ce_d = busy_d || wt_en_d;
  end

  // State and registered outputs.
  always_ff @(posedge trig_clk) begin
    if (trig_rst) begin
      state_q     <= IDLE;
      pre_eff_q   <= '0;
      pre_cnt_q   <= '0;
      post_rem_q  <= '0;
      trig_addr_q <= '0;
      wt_addr_q   <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      wt_en_q     <= 1'b0;
      wt_ce_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_eff_q   <= pre_eff_d;
      pre_cnt_q   <= pre_cnt_d;
      post_rem_q  <= post_rem_d;
      trig_addr_q <= trig_addr_d;
      wt_addr_q   <= wt_addr_d;
      triggered_q <= triggered_d;
      wrapped_q   <= wrapped_d;
      wt_en_q     <= wt_en_d;
      wt_ce_q     <= wt_ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.wt_ce     = wt_ce_q;
  assign bus.wt_en     = wt_en_q;
  assign bus.wt_addr   = wt_addr_q;
  assign bus.busy      = busy_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.trig_addr = trig_addr_q;
endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Directed and random checks of cwc_capture_ctrl at DEPTH=8 against a sample-count model.
module tb_cwc_capture_ctrl;
  localparam int AW    = 16;
  localparam int DEPTH = 8;

  logic trig_clk;
  logic trig_rst;

  cwc_capture_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  cwc_capture_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .trig_clk (trig_clk),
    .trig_rst (trig_rst),
    .bus      (bus)
  );

  initial trig_clk = 1'b0;
  always #5 trig_clk = ~trig_clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int strobes = 0;

  // Reference model: a window is described by how many samples were stored so far.
  bit m_active, m_fin, m_en;
  int m_n, m_pre, m_trig, m_taddr, m_waddr;

  task automatic model_update(input bit a, input bit ab, input bit s, input bit t,
                              input logic [AW-1:0] p, input bit r);
    m_en = 1'b0;
    if (r) begin
      m_active = 0; m_fin = 0; m_n = 0; m_trig = -1; m_taddr = 0; m_waddr = 0; m_pre = 0;
    end else if (ab) begin
      m_active = 0; m_fin = 0; m_n = 0; m_trig = -1;
    end else if (a && !m_active) begin
      m_active = 1; m_fin = 0; m_n = 0; m_trig = -1; m_taddr = 0;
      m_pre = (int'(p) > DEPTH - 1) ? DEPTH - 1 : int'(p);
    end else if (m_active && s) begin
      m_en    = 1'b1;
      m_waddr = m_n % DEPTH;
      if (m_trig < 0 && m_n >= m_pre && t) begin
        m_trig  = m_n;
        m_taddr = m_waddr;
      end
      m_n++;
      if (m_trig >= 0 && m_n == m_trig + DEPTH - m_pre) begin
        m_active = 0;
        m_fin    = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",      32'(bus.busy),      32'(m_active));
    chk("done",      32'(bus.done),      32'(m_fin));
    chk("triggered", 32'(bus.triggered), 32'(m_trig >= 0));
    chk("wrapped",   32'(bus.wrapped),   32'(m_n >= DEPTH));
    chk("wt_en",     32'(bus.wt_en),     32'(m_en));
    chk("wt_ce",     32'(bus.wt_ce),     32'(m_active | m_en));
    chk("wt_addr",   32'(bus.wt_addr),   32'(m_waddr));
    chk("trig_addr", 32'(bus.trig_addr), 32'(m_taddr));
  endtask

  task automatic step(input bit a, input bit ab, input bit s, input bit t,
                      input logic [AW-1:0] p, input bit r);
    bus.arm = a; bus.abort = ab; bus.sample_en = s; bus.trigger = t; bus.pre_len = p;
    trig_rst = r;
    @(posedge trig_clk);
    model_update(a, ab, s, t, p, r);
    #1;
    check_all();
    if (bus.wt_en === 1'b1) strobes++;
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b0; bus.trigger = 1'b0;
    bus.pre_len = '0; trig_rst = 1'b1;
    step(0, 0, 0, 0, 16'd0, 1);
    step(0, 0, 1, 1, 16'd0, 1);
    step(0, 0, 1, 0, 16'd0, 0);

    // Basic window: trigger on 6th sample, writes 0..7,0,1
    step(1, 0, 0, 0, 16'd3, 0);
    strobes = 0;
    for (int i = 1; i <= 12; i++) step(0, 0, 1, (i == 6), 16'd0, 0);
    chk("t1_strobes",   32'(strobes),       32'd10);
    chk("t1_trig_addr", 32'(bus.trig_addr), 32'd5);
    chk("t1_wrapped",   32'(bus.wrapped),   32'd1);
    chk("t1_done",      32'(bus.done),      32'd1);

    // Trigger held from arm is ignored in PRE
    step(1, 0, 0, 1, 16'd3, 0);
    strobes = 0;
    for (int i = 1; i <= 12; i++) step(0, 0, 1, 1, 16'd0, 0);
    chk("t2_strobes",   32'(strobes),       32'd8);
    chk("t2_trig_addr", 32'(bus.trig_addr), 32'd3);

    // Clamp to DEPTH-1 with zero post window
    step(1, 0, 0, 0, 16'd20, 0);
    strobes = 0;
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 1, 16'd0, 0);
    step(0, 0, 1, 1, 16'd0, 0);
    chk("t3_done_with_trig", 32'(bus.done & bus.wt_en), 32'd1);
    chk("t3_trig_addr",      32'(bus.trig_addr),        32'd7);
    step(0, 0, 1, 0, 16'd0, 0);
    chk("t3_strobes", 32'(strobes), 32'd8);

    // Gapped samples, trigger only in the gaps
    step(1, 0, 0, 0, 16'd0, 0);
    strobes = 0;
    for (int i = 0; i < 12; i++) step(0, 0, (i % 2 == 0), (i % 2 == 1), 16'd0, 0);
    chk("t4_no_trig", 32'(bus.triggered), 32'd0);
    chk("t4_strobes", 32'(strobes),       32'd6);

    // Abort and arm together during POST
    step(0, 1, 0, 0, 16'd0, 0);
    step(1, 0, 0, 0, 16'd2, 0);
    for (int i = 1; i <= 6; i++) step(0, 0, 1, (i == 4), 16'd0, 0);
    step(1, 1, 1, 0, 16'd2, 0);
    strobes = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'd0, 0);
    chk("t5_no_strobes", 32'(strobes),  32'd0);
    chk("t5_idle_busy",  32'(bus.busy), 32'd0);
    step(1, 0, 0, 0, 16'd0, 0);
    step(0, 0, 1, 0, 16'd0, 0);
    chk("t5_restart_addr", 32'(bus.wt_addr), 32'd0);

    // Reset during WAIT, then arm while busy is ignored
    step(0, 0, 1, 0, 16'd0, 0);
    step(0, 0, 1, 0, 16'd0, 1);
    chk("t6_rst_busy",  32'(bus.busy),  32'd0);
    chk("t6_rst_wt_ce", 32'(bus.wt_ce), 32'd0);
    step(1, 0, 0, 0, 16'd1, 0);
    step(0, 0, 1, 0, 16'd0, 0);
    step(1, 0, 1, 0, 16'd5, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 16'd0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           16'($urandom_range(0, 12)), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cwc_capture_ctrl.md
# cwc_capture_ctrl

Trace-capture sequencer for the ChipWatcher core. It runs in the `trig_clk` domain between the trigger logic and the trace RAM. It owns the trace-RAM write port (`wt_ce`, `wt_en`, `wt_addr`) and applies a configurable pre-/post-trigger window over a circular buffer of `DEPTH` entries. It reports trigger position and completion back to the JTAG status register.

## Interface
- `ADDR_WIDTH`, default 16: width of `wt_addr`, `pre_len` and `trig_addr`.
- `DEPTH`, default 2730: number of trace-RAM entries. Legal range is 2 ≤ `DEPTH` ≤ 2**`ADDR_WIDTH`.
- `trig_clk`, input, 1: capture clock.
- `trig_rst`, input, 1: synchronous, active-high reset.
- `arm`, input, 1: start-capture pulse.
- `abort`, input, 1: cancel-capture pulse.
- `sample_en`, input, 1: storage qualifier; the current sample is valid.
- `trigger`, input, 1: trigger-condition hit for the current sample.
- `pre_len`, input, `ADDR_WIDTH`: requested number of pre-trigger samples. Latched on accepted `arm`.
- `wt_ce`, output, 1: trace-RAM chip enable.
- `wt_en`, output, 1: trace-RAM write strobe.
- `wt_addr`, output, `ADDR_WIDTH`: trace-RAM write address.
- `busy`, output, 1: capture is in progress.
- `triggered`, output, 1: trigger was accepted in this capture.
- `done`, output, 1: capture window is complete.
- `wrapped`, output, 1: write pointer has wrapped at least once.
- `trig_addr`, output, `ADDR_WIDTH`: RAM address holding the trigger sample.

## Operation
- States: `IDLE`, `PRE`, `WAIT`, `POST`, `DONE`.
- Reset values: state `IDLE`; every output 0; internal pointer and counters 0.
- **Arm**
  - `arm` is accepted only in `IDLE` or `DONE`. It is ignored in `PRE`, `WAIT` and `POST`.
  - On acceptance: latch `pre_eff = min(pre_len, DEPTH-1)`, clear the pointer, `triggered`, `done`, `wrapped` and `trig_addr`.
  - Next state is `PRE` if `pre_eff > 0`, otherwise `WAIT`.
- **Qualified sample**: `sample_en=1` while in `PRE`, `WAIT` or `POST`.
  - It produces exactly one write at the current pointer.
  - The pointer then increments modulo `DEPTH`; `DEPTH-1` wraps to 0 and sets `wrapped`.
- **PRE**
  - `trigger` is ignored.
  - Counts qualified samples. After the `pre_eff`-th sample, go to `WAIT`.
- **WAIT**
  - Writes circularly.
  - `trigger` & `sample_en` in the same cycle: that sample is written, `trig_addr` takes the pointer value, `triggered` is set, and `post_rem = DEPTH-1-pre_eff` is loaded.
  - Next state is `POST`, or `DONE` if `post_rem == 0`.
  - `trigger` without `sample_en` is ignored.
- **POST**
  - Each qualified sample decrements `post_rem`.
  - The sample that brings it to 0 is the final write; go to `DONE`.
  - `trigger` is ignored.
- **DONE**
  - `done=1` and `busy=0`; no writes.
  - Status outputs hold until the next accepted `arm` or `abort`.
- **Oldest sample** in the window is at `(trig_addr - pre_eff) mod DEPTH`. Software computes this.
- **Abort**
  - From any state: go to `IDLE`.
  - Clear `busy`, `triggered`, `done` and `wrapped`. `wt_ce` and `wt_en` are 0 from the next cycle.
  - `abort` and `arm` in the same cycle: `abort` wins.
- `trig_rst` mid-capture behaves like reset: everything returns to reset values.
- Arithmetic: pointer and counters are `ADDR_WIDTH` wide. Wrap is a compare against `DEPTH-1`, never a power-of-two overflow.

## Timing
- All outputs are registered.
- Write latency is 1 cycle. A qualified sample in cycle N gives `wt_en=1`, `wt_ce=1` and `wt_addr` = its address in cycle N+1. The datapath delays sample data by one register to match.
- `wt_ce` is 1 in every cycle where the state is `PRE`/`WAIT`/`POST` or `wt_en=1`.
- Arm at cycle N: `busy=1` at N+1. The earliest write strobe is at N+2, to address 0.
- Final qualified sample at cycle K: `wt_en=1` and `done=1` at K+1. `wt_ce=0` from K+2.
- `triggered` and `trig_addr` update in the same cycle as the trigger sample's `wt_en`.
- Sustained `sample_en=1` gives one write per cycle with no bubbles, including across wrap.

## Structure
- Shared package `cwc_pkg`:
  - state enum `cwc_cap_state_t` (`IDLE`, `PRE`, `WAIT`, `POST`, `DONE`);
  - default-constant localparams for `DEPTH` and `ADDR_WIDTH`, shared with the top-level wrapper.
- One sub-module, `cwc_wrap_ptr`: a modulo-`DEPTH` counter with clear, increment and a wrap-pulse output. It is used for the write pointer.
- The FSM and the pre/post counters stay in `cwc_capture_ctrl`.

## Test plan
- Run at `DEPTH=8`.
- **Basic window**: `pre_len=3`, `arm`, continuous `sample_en`, `trigger` on the 6th sample. Expect writes to addresses 0,1,2,3,4,5,6,7,0,1. `trig_addr=5`, `wrapped=1`. Expect 10 strobes total, then `done=1`.
- **Trigger ignored in PRE**: `pre_len=3`, `trigger` held high from arm. Expect the trigger to be accepted on the 4th sample, `trig_addr=3`, 8 writes total.
- **Clamp and zero post**: `pre_len=20` clamps to 7. Trigger on the 8th sample gives `post_rem=0`. Expect `done` in the same cycle as the trigger strobe and `trig_addr=7`.
- **Gaps and unqualified trigger**: `pre_len=0`, `sample_en` toggling 1010…, `trigger` pulsed while `sample_en=0`. Expect no trigger, no strobe in gap cycles and contiguous addresses.
- **Abort/arm collision**: mid-`POST`, assert `abort` and `arm` together. Expect `IDLE` next cycle, all status 0 and no strobes. A later `arm` restarts at address 0.
- **Reset mid-capture**: `trig_rst` pulsed during `WAIT`. Expect all outputs 0 on the next cycle; `arm` while busy is ignored.
